// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the program/data memory port arbiter:
// FSM state encoding, requester ids and default bus widths (the same
// ADDR_W/DATA_W defaults are used by Control and the register file).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// using the last owner; without it fetch has fixed priority.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic fetch_req_i,
  input  logic data_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant_i,
`endif
  output logic winner_o
);

  // Winner is only meaningful when at least one request is high.
  always_comb begin
    winner_o = REQ_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (fetch_req_i && data_req_i) begin
      winner_o = (last_grant_i == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (data_req_i) begin
      winner_o = REQ_DATA;
    end
`else
    if (!fetch_req_i && data_req_i) begin
      winner_o = REQ_DATA;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: grants one of fetch/data at a time, drives
// one-cycle memory strobes, waits out MEM_LAT cycles on reads, and returns
// registered read data with a one-cycle done pulse to the owner.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break with
// last_grant tracking; default build is fixed fetch priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  arb_state_e        state_q;
  logic              owner_q;
  logic              we_q;
  logic [3:0]        cnt_q;
  logic              fetch_gnt_q, fetch_done_q;
  logic              data_gnt_q, data_done_q;
  logic              mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;
`endif

  arb_pick u_pick (
    .fetch_req_i  (fetch_req),
    .data_req_i   (data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .winner_o     (winner)
  );

  // Access sequencer: arbitration, strobes, latency wait and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_FETCH;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      fetch_gnt_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      data_gnt_q   <= 1'b0;
      data_done_q  <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_DATA;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_req || data_req) begin
            owner_q <= winner;
            state_q <= ST_ACCESS;
            if (winner == REQ_FETCH) begin
              // Fetch is always a read; write data latch is left untouched.
              mem_addr_q  <= fetch_addr;
              we_q        <= 1'b0;
              fetch_gnt_q <= 1'b1;
              mem_rd_q    <= 1'b1;
            end else begin
              mem_addr_q  <= data_addr;
              mem_wdata_q <= data_wdata;
              we_q        <= data_we;
              data_gnt_q  <= 1'b1;
              mem_rd_q    <= !data_we;
              mem_wr_q    <= data_we;
            end
          end
        end
        ST_ACCESS: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (we_q) begin
            state_q      <= ST_DONE;
            fetch_done_q <= (owner_q == REQ_FETCH);
            data_done_q  <= (owner_q == REQ_DATA);
          end else begin
            cnt_q   <= LAT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Counter about to hit zero: this cycle carries valid mem_rdata.
          if (cnt_q == 4'd1) begin
            rdata_q      <= mem_rdata;
            state_q      <= ST_DONE;
            fetch_done_q <= (owner_q == REQ_FETCH);
            data_done_q  <= (owner_q == REQ_DATA);
          end
        end
        ST_DONE: begin
          fetch_done_q <= 1'b0;
          data_done_q  <= 1'b0;
          fetch_gnt_q  <= 1'b0;
          data_gnt_q   <= 1'b0;
          state_q      <= ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_q <= owner_q;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fetch_gnt  = fetch_gnt_q;
  assign fetch_done = fetch_done_q;
  assign data_gnt   = data_gnt_q;
  assign data_done  = data_done_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model with MEM_LAT read
// pipeline, expected completions queued at drive time and checked on done.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, data_req, data_we;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic          fetch_gnt, fetch_done, data_gnt, data_done;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model with MEM_LAT-deep read pipeline.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:LAT-1];
  assign mem_rdata = rpipe[LAT-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = 16'(i) ^ 16'h5A00;
    mem_model[5] = 16'h1234;
  end

  always @(posedge clk) begin
    if (mem_wr) mem_model[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_rd ? mem_model[mem_addr] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  typedef struct {
    logic          owner;
    logic          is_read;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_rd || mem_wr) chk("strobe_excl", 64'(mem_rd & mem_wr), 64'd0);
      if (fetch_done || data_done) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 64'({fetch_done, data_done}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_one_done", 64'(fetch_done & data_done), 64'd0);
          chk("sb_owner", 64'(data_done), 64'(e.owner));
          if (e.is_read) chk("sb_rdata", 64'(rdata), 64'(e.rdata));
        end
      end
    end
  end

  function automatic logic [50:0] all_outs();
    return {fetch_gnt, fetch_done, data_gnt, data_done, mem_rd, mem_wr,
            mem_addr, mem_wdata, rdata};
  endfunction

  task automatic set_req(input logic who, input logic v);
    if (who == REQ_FETCH) fetch_req = v;
    else data_req = v;
  endtask

  // From negedge of cycle start_k, wait for the owner's done; expect it at exp_k.
  task automatic finish_access(input logic who, input int start_k, input int exp_k);
    int  k;
    bit  seen;
    k = start_k;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if ((who == REQ_FETCH) ? fetch_done : data_done) begin
        seen = 1;
        chk("done_cycle", 64'(k), 64'(exp_k));
        set_req(who, 1'b0);
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'(k), 64'(exp_k));
      set_req(who, 1'b0);
    end
  endtask

  // Called at the negedge of an IDLE cycle (cycle 0).
  task automatic do_access(input logic who, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
    exp_t          e;
    logic [DW-1:0] rd_before;
    e.owner   = who;
    e.is_read = !we;
    e.rdata   = mem_model[addr];
    exp_q.push_back(e);
    rd_before = rdata;
    if (who == REQ_FETCH) begin
      fetch_addr = addr;
      fetch_req  = 1'b1;
    end else begin
      data_addr  = addr;
      data_we    = we;
      data_wdata = wd;
      data_req   = 1'b1;
    end
    @(negedge clk);
    chk("c1_fetch_gnt", 64'(fetch_gnt), 64'(who == REQ_FETCH));
    chk("c1_data_gnt", 64'(data_gnt), 64'(who == REQ_DATA));
    chk("c1_strobes", 64'({mem_rd, mem_wr}), 64'({!we, we}));
    chk("c1_mem_addr", 64'(mem_addr), 64'(addr));
    if (we) chk("c1_mem_wdata", 64'(mem_wdata), 64'(wd));
    finish_access(who, 1, we ? 2 : 2 + LAT);
    if (we) chk("wr_rdata_hold", 64'(rdata), 64'(rd_before));
    chk("done_addr_hold", 64'(mem_addr), 64'(addr));
  endtask

  initial begin
    exp_t e;
    int   ndone;
    int   dgnt_cycles;

    reset = 1'b1;
    fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    fetch_addr = 13'h0005; data_addr = 13'h0010; data_wdata = '0;

    // Reset held 3 cycles with both requests high.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", 64'(all_outs()), 64'd0);
    end
    e.owner = REQ_FETCH; e.is_read = 1'b1; e.rdata = 16'h1234;
    exp_q.push_back(e);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_fetch_gnt", 64'(fetch_gnt), 64'd1);
    chk("post_reset_data_gnt", 64'(data_gnt), 64'd0);
    chk("post_reset_mem_addr", 64'(mem_addr), 64'h5);
    data_req = 1'b0;
    finish_access(REQ_FETCH, 1, 2 + LAT);

    // Fetch read, data write, data read-back.
    @(negedge clk);
    do_access(REQ_FETCH, 1'b0, 13'h0005, 16'h0000);
    @(negedge clk);
    do_access(REQ_DATA, 1'b1, 13'h1FFF, 16'hBEEF);
    @(negedge clk);
    do_access(REQ_DATA, 1'b0, 13'h1FFF, 16'h0000);
    chk("readback", 64'(rdata), 64'hBEEF);
    @(negedge clk);
    do_access(REQ_FETCH, 1'b0, 13'h0042, 16'h0000);

    // Fetch request dropped in cycle 2 of a read.
    @(negedge clk);
    e.owner = REQ_FETCH; e.is_read = 1'b1; e.rdata = mem_model[13'h0020];
    exp_q.push_back(e);
    fetch_addr = 13'h0020;
    fetch_req  = 1'b1;
    @(negedge clk);
    chk("drop_c1_gnt", 64'(fetch_gnt), 64'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    finish_access(REQ_FETCH, 2, 2 + LAT);
    @(negedge clk);
    chk("drop_idle", 64'({fetch_gnt, data_gnt, mem_rd, mem_wr}), 64'd0);
    @(negedge clk);
    chk("drop_no_regrant", 64'({fetch_gnt, data_gnt, mem_rd, mem_wr}), 64'd0);

    // Both requests held continuously for 4 accesses.
    fetch_addr = 13'h0005;
    data_addr = 13'h0100; data_we = 1'b1; data_wdata = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      e.owner = (i % 2 == 0) ? REQ_FETCH : REQ_DATA;
`else
      e.owner = REQ_FETCH;
`endif
      e.is_read = (e.owner == REQ_FETCH);
      e.rdata   = 16'h1234;
      exp_q.push_back(e);
    end
    fetch_req = 1'b1; data_req = 1'b1;
    ndone = 0; dgnt_cycles = 0;
    for (int k = 0; k < 60 && ndone < 4; k++) begin
      @(negedge clk);
      if (data_gnt) dgnt_cycles++;
      if (fetch_done || data_done) ndone++;
      if (ndone == 4) begin
        fetch_req = 1'b0; data_req = 1'b0;
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    chk("both_ndone", 64'(ndone), 64'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("rr_data_gnt_seen", 64'(dgnt_cycles != 0), 64'd1);
`else
    chk("fixed_data_starved", 64'(dgnt_cycles), 64'd0);
`endif

    // Reset during WAIT abandons the read.
    @(negedge clk);
    @(negedge clk);
    fetch_addr = 13'h0007;
    fetch_req  = 1'b1;
    @(negedge clk);
    chk("abort_c1_gnt", 64'(fetch_gnt), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("abort_reset_outs", 64'(all_outs()), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_rdata", 64'(rdata), 64'd0);
      chk("abort_no_done", 64'({fetch_done, data_done, fetch_gnt, data_gnt}), 64'd0);
    end

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
